// File: rtl/step_gen_pkg.sv
// rtl/step_gen_pkg.sv - shared types and register map for the stepper pulse generator
package step_gen_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} sg_state_t;

  localparam logic [1:0] SG_CTRL   = 2'd0;
  localparam logic [1:0] SG_STEPS  = 2'd1;
  localparam logic [1:0] SG_HALF   = 2'd2;
  localparam logic [1:0] SG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_DIR      = 1;
  localparam int CTRL_START    = 2;
  localparam int CTRL_ABORT    = 3;
  localparam int CTRL_DONE_CLR = 4;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter pacing the setup delay and both pulse halves
module step_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Loading N makes the owning state last exactly N cycles.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/step_gen.sv
// rtl/step_gen.sv - memory-mapped stepper pulse generator with counted steps and direction setup
module step_gen
  import step_gen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 20,
  parameter int MIN_HALF  = 16,
  parameter int DIR_SETUP = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] WriteData,
  input  logic [1:0]  addr,
  input  logic        MemWrite,
  input  logic        cs,
  output logic [31:0] ReadData,
  output logic        ena,
  output logic        dir,
  output logic        pul
);

  sg_state_t        state_q, next_state;
  logic             en_q, dir_req_q, done_q;
  logic [CNT_W-1:0] steps_q, remaining_q;
  logic [PER_W-1:0] half_q, half_eff, tmr_value;
  logic             tmr_load, expire;
  logic             wr, wr_ctrl, abort_req, start_req, clr_req, stop_req, start_ok;
  logic [31:0]      rdata;
  logic             unused;

  assign wr        = MemWrite & ~cs;
  assign wr_ctrl   = wr && (addr == SG_CTRL);
  assign abort_req = wr_ctrl & WriteData[CTRL_ABORT];
  assign start_req = wr_ctrl & WriteData[CTRL_START] & ~WriteData[CTRL_ABORT];
  assign clr_req   = wr_ctrl & WriteData[CTRL_DONE_CLR] & ~WriteData[CTRL_START] & ~WriteData[CTRL_ABORT];
  // Writing CTRL with en=0 stops a run just like abort does.
  assign stop_req  = abort_req | (wr_ctrl & ~WriteData[CTRL_EN]);
  assign start_ok  = (state_q == IDLE) && start_req && WriteData[CTRL_EN];
  assign half_eff  = (half_q < PER_W'(MIN_HALF)) ? PER_W'(MIN_HALF) : half_q;
  assign unused    = ^WriteData[31:PER_W];

  step_timer #(.W(PER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (expire)
  );

  always_comb begin
    next_state = state_q;
    tmr_load   = 1'b0;
    tmr_value  = half_eff;
    case (state_q)
      IDLE: begin
        if (start_ok && (steps_q != '0)) begin
          next_state = SETUP;
          tmr_load   = 1'b1;
          tmr_value  = PER_W'(DIR_SETUP + 1);
        end
      end
      SETUP: if (expire) begin next_state = HIGH; tmr_load = 1'b1; end
      HIGH:  if (expire) begin next_state = LOW;  tmr_load = 1'b1; end
      LOW: begin
        if (expire) begin
          if (remaining_q != '0) begin
            next_state = HIGH;
            tmr_load   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (stop_req && (state_q != IDLE)) begin
      next_state = IDLE;
      tmr_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pul         <= 1'b0;
      dir         <= 1'b0;
      en_q        <= 1'b0;
      dir_req_q   <= 1'b0;
      done_q      <= 1'b0;
      steps_q     <= '0;
      half_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= next_state;
      pul     <= (next_state == HIGH);
      if (wr_ctrl) begin
        en_q      <= WriteData[CTRL_EN];
        dir_req_q <= WriteData[CTRL_DIR];
      end
      if (wr && (addr == SG_STEPS)) steps_q <= WriteData[CNT_W-1:0];
      if (wr && (addr == SG_HALF))  half_q  <= WriteData[PER_W-1:0];
      if (start_ok) begin
        dir         <= WriteData[CTRL_DIR];
        remaining_q <= steps_q;
        done_q      <= (steps_q == '0);
      end else if (clr_req) begin
        done_q <= 1'b0;
      end
      if (!stop_req) begin
        if ((state_q == HIGH) && expire) remaining_q <= remaining_q - CNT_W'(1);
        if ((state_q == LOW) && expire && (remaining_q == '0)) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      SG_CTRL:   rdata[1:0] = {dir_req_q, en_q};
      SG_STEPS:  rdata[CNT_W-1:0] = steps_q;
      SG_HALF:   rdata[PER_W-1:0] = half_q;
      SG_STATUS: begin
        rdata[16 +: CNT_W] = remaining_q;
        rdata[1]           = done_q;
        rdata[0]           = (state_q != IDLE);
      end
      default: rdata = '0;
    endcase
  end

  assign ReadData = cs ? 32'bz : rdata;
  assign ena      = en_q;

endmodule
